weight_fetch_responder: RTL and testbench

WEIGHT_FETCH_RESPONDER -- requirements
Module: weight_fetch_responder

---
 rtl/accel_pkg.sv | 27 ++
 rtl/weight_buf.sv | 37 +++
 rtl/weight_fetch_responder.sv | 138 +++++++++++++
 tb/tb_weight_fetch_responder.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared constants and state encodings for the accelerator and its weight fetch path.
package accel_pkg;

    localparam int unsigned BURST_LEN_DEF = 16;
    localparam int unsigned DATA_W_DEF    = 16;
    localparam int unsigned ADDR_W_DEF    = 16;
    localparam int unsigned PE_COUNT      = BURST_LEN_DEF;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReq   = 2'd1,
        StFill  = 2'd2,
        StValid = 2'd3
    } wf_state_e;

    typedef enum logic [1:0] {
        AccIdle    = 2'd0,
        AccLoadW   = 2'd1,
        AccCompute = 2'd2,
        AccDrain   = 2'd3
    } acc_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/weight_buf.sv
// Burst buffer: one write port, one registered read port; storage itself is not reset.
module weight_buf
    import accel_pkg::*;
#(
    parameter int unsigned Depth = BURST_LEN_DEF,
    parameter int unsigned Width = DATA_W_DEF
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        we_i,
    input  logic [idx_width(Depth)-1:0] waddr_i,
    input  logic [Width-1:0]            wdata_i,
    input  logic                        re_i,
    input  logic [idx_width(Depth)-1:0] raddr_i,
    output logic [Width-1:0]            rdata_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/weight_fetch_responder.sv
// Fetches one BURST_LEN-word weight burst from memory per request and serves it
// to the PE array from a local buffer.
module weight_fetch_responder
    import accel_pkg::*;
#(
    parameter int unsigned BURST_LEN = BURST_LEN_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cfg_wr,
    input  logic [ADDR_W-1:0]               cfg_data,
    input  logic                            rd_req,
    output logic                            mem_req,
    output logic [ADDR_W-1:0]               mem_addr,
    input  logic                            mem_ready,
    input  logic [DATA_W-1:0]               mem_rdata,
    input  logic                            mem_rvalid,
    output logic                            dval,
    input  logic                            fifo_rd,
    input  logic [idx_width(BURST_LEN)-1:0] fifo_idx,
    output logic [DATA_W-1:0]               weight_out,
    output logic                            busy,
    output logic                            err
);

    localparam int unsigned IdxW = idx_width(BURST_LEN);

    wf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;

    logic in_rest, in_busy, in_valid, beat, last_beat, cfg_accept, fetch_start, err_set;

    assign in_rest     = (state_q == StIdle) || (state_q == StValid);
    assign in_busy     = (state_q == StReq) || (state_q == StFill);
    assign in_valid    = (state_q == StValid);
    assign beat        = (state_q == StFill) && mem_rvalid;
    assign last_beat   = (cnt_q == IdxW'(BURST_LEN - 1));
    assign cfg_accept  = in_rest && cfg_wr;
    assign fetch_start = in_rest && rd_req && !cfg_wr;
    // Dropped strobes and out-of-window reads all count as protocol violations.
    assign err_set     = (in_busy && (cfg_wr || rd_req)) || (in_rest && cfg_wr && rd_req) ||
                         (fifo_rd && !in_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StValid: begin
                if (cfg_wr) begin
                    state_d = StIdle;
                end else if (rd_req) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (mem_ready) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                if (beat && last_beat) begin
                    state_d = StValid;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_req  = (state_q == StReq);
        mem_addr = (state_q == StReq) ? ptr_q : '0;
        busy     = in_busy;
        dval     = in_valid;
        err      = err_q;
    end

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        err_d = err_q;
        if (cfg_accept) begin
            ptr_d = cfg_data;
            err_d = 1'b0;
        end
        if (fetch_start) begin
            cnt_d = '0;
        end
        if (beat) begin
            if (last_beat) begin
                cnt_d = '0;
                ptr_d = ptr_q + ADDR_W'(BURST_LEN);
            end else begin
                cnt_d = cnt_q + IdxW'(1);
            end
        end
        if (err_set) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    weight_buf #(
        .Depth (BURST_LEN),
        .Width (DATA_W)
    ) u_weight_buf (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (beat),
        .waddr_i (cnt_q),
        .wdata_i (mem_rdata),
        .re_i    (fifo_rd && in_valid),
        .raddr_i (fifo_idx),
        .rdata_o (weight_out)
    );

endmodule

// File: tb/tb_weight_fetch_responder.sv
// Self-checking bench for weight_fetch_responder against a burst-level reference model.
module tb_weight_fetch_responder;

    localparam int BL = 16;
    localparam int DW = 16;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst, cfg_wr, rd_req, mem_ready, mem_rvalid, fifo_rd;
    logic [AW-1:0] cfg_data;
    logic [DW-1:0] mem_rdata;
    logic [3:0]    fifo_idx;
    logic          mem_req, dval, busy, err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] weight_out;

    int checks = 0;
    int errors = 0;

    // Reference model: buffer image, next burst address, last word read out.
    logic [DW-1:0] m_buf [BL];
    logic [AW-1:0] m_ptr;
    logic [DW-1:0] m_wout;

    always #5 clk = ~clk;

    weight_fetch_responder #(
        .BURST_LEN (BL),
        .DATA_W    (DW),
        .ADDR_W    (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_wr     (cfg_wr),
        .cfg_data   (cfg_data),
        .rd_req     (rd_req),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .dval       (dval),
        .fifo_rd    (fifo_rd),
        .fifo_idx   (fifo_idx),
        .weight_out (weight_out),
        .busy       (busy),
        .err        (err)
    );

    task automatic do_cfg(input logic [AW-1:0] addr);
        cfg_wr = 1'b1;
        cfg_data = addr;
        @(negedge clk);
        cfg_wr = 1'b0;
        m_ptr = addr;
    endtask

    // Pulses rd_req, waits (bounded) for mem_req and completes the handshake.
    task automatic start_fetch(input bit rnd, output logic [AW-1:0] addr, output bit tmo);
        int n;
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        tmo = (mem_req !== 1'b1);
        addr = mem_addr;
        if (rnd) repeat ($urandom_range(0, 3)) @(negedge clk);
        mem_ready = 1'b1;
        if (rnd) begin
            mem_rvalid = 1'b1;
            mem_rdata = 16'hDEAD;
        end
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic send_beats(input int first, input int n, input bit seq, input bit rnd);
        for (int i = first; i < first + n; i++) begin
            if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
            mem_rvalid = 1'b1;
            mem_rdata = seq ? DW'(i + 1) : DW'($urandom);
            m_buf[i] = mem_rdata;
            @(negedge clk);
            mem_rvalid = 1'b0;
        end
        if (first + n == BL) m_ptr = m_ptr + AW'(BL);
    endtask

    task automatic read_word(input int idx, output logic [DW-1:0] d);
        fifo_idx = 4'(idx);
        fifo_rd = 1'b1;
        @(negedge clk);
        fifo_rd = 1'b0;
        d = weight_out;
        m_wout = m_buf[idx];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
        checks++; if (dval !== 1'b0) begin errors++; $display("FAIL reset_dval got %b exp 0", dval); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        checks++; if (weight_out !== '0) begin errors++; $display("FAIL reset_wout got %h exp 0", weight_out); end
        @(negedge clk);
        rst = 1'b0;
        m_ptr = '0;
        m_wout = '0;
    endtask

    task automatic test_basic();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit tmo;
        do_cfg(16'h0100);
        start_fetch(1'b0, a, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL basic_timeout mem_req never rose"); end
        checks++; if (a !== 16'h0100) begin errors++; $display("FAIL basic_addr got %h exp 0100", a); end
        checks++; if (mem_req !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL basic_fill mem_req %b busy %b exp 0 1", mem_req, busy);
        end
        send_beats(0, 15, 1'b1, 1'b0);
        checks++; if (dval !== 1'b0) begin errors++; $display("FAIL basic_dval_early got %b exp 0", dval); end
        send_beats(15, 1, 1'b1, 1'b0);
        checks++; if (dval !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_dval got %b busy %b exp 1 0", dval, busy);
        end
        read_word(5, d);
        checks++; if (d !== 16'h0006) begin errors++; $display("FAIL basic_read5 got %h exp 0006", d); end
        @(negedge clk);
        checks++; if (weight_out !== m_wout) begin
            errors++; $display("FAIL basic_hold got %h exp %h", weight_out, m_wout);
        end
    endtask

    task automatic test_second_fetch();
        logic [DW-1:0] d;
        int idx;
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        checks++; if (dval !== 1'b0) begin errors++; $display("FAIL second_dval got %b exp 0", dval); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0110) begin
            errors++; $display("FAIL second_addr req %b addr %h exp 1 0110", mem_req, mem_addr);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        send_beats(0, BL, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            idx = int'($urandom_range(0, BL - 1));
            read_word(idx, d);
            checks++; if (d !== m_buf[idx]) begin
                errors++; $display("FAIL second_read idx %0d got %h exp %h", idx, d, m_buf[idx]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit tmo;
        do_cfg(16'hFFF0);
        start_fetch(1'b1, a, tmo);
        checks++; if (tmo || a !== 16'hFFF0) begin
            errors++; $display("FAIL wrap_first got %h tmo %b exp fff0", a, tmo);
        end
        send_beats(0, BL, 1'b0, 1'b1);
        start_fetch(1'b1, a, tmo);
        checks++; if (tmo || a !== 16'h0000) begin
            errors++; $display("FAIL wrap_second got %h tmo %b exp 0000", a, tmo);
        end
        send_beats(0, BL, 1'b0, 1'b1);
        for (int i = 0; i < BL; i++) begin
            read_word(i, d);
            checks++; if (d !== m_buf[i]) begin
                errors++; $display("FAIL wrap_read idx %0d got %h exp %h", i, d, m_buf[i]);
            end
        end
    endtask

    task automatic test_drops();
        logic [AW-1:0] a, exp_a;
        logic [DW-1:0] d;
        int idx;
        bit tmo;
        do_cfg(16'h0200);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL drop_err_init got %b exp 0", err); end
        start_fetch(1'b1, a, tmo);
        send_beats(0, 4, 1'b0, 1'b1);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        checks++; if (err !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL drop_rdreq err %b busy %b exp 1 1", err, busy);
        end
        send_beats(4, 4, 1'b0, 1'b1);
        cfg_wr = 1'b1;
        cfg_data = 16'h1234;
        @(negedge clk);
        cfg_wr = 1'b0;
        checks++; if (err !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL drop_cfg err %b busy %b exp 1 1", err, busy);
        end
        send_beats(8, 8, 1'b0, 1'b1);
        checks++; if (dval !== 1'b1) begin errors++; $display("FAIL drop_complete dval %b exp 1", dval); end
        for (int k = 0; k < 3; k++) begin
            idx = int'($urandom_range(0, BL - 1));
            read_word(idx, d);
            checks++; if (d !== m_buf[idx]) begin
                errors++; $display("FAIL drop_read idx %0d got %h exp %h", idx, d, m_buf[idx]);
            end
        end
        exp_a = m_ptr;
        start_fetch(1'b1, a, tmo);
        checks++; if (tmo || a !== exp_a || exp_a !== 16'h0210) begin
            errors++; $display("FAIL drop_next_addr got %h exp 0210", a);
        end
        send_beats(0, BL, 1'b0, 1'b1);
        do_cfg(16'h0300);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL drop_err_clear got %b exp 0", err); end
        fifo_idx = 4'd0;
        fifo_rd = 1'b1;
        @(negedge clk);
        fifo_rd = 1'b0;
        checks++; if (err !== 1'b1 || weight_out !== m_wout) begin
            errors++; $display("FAIL idle_read err %b wout %h exp 1 %h", err, weight_out, m_wout);
        end
        do_cfg(16'h0300);
        start_fetch(1'b1, a, tmo);
        send_beats(0, BL, 1'b0, 1'b1);
        cfg_wr = 1'b1;
        cfg_data = 16'h0400;
        rd_req = 1'b1;
        @(negedge clk);
        cfg_wr = 1'b0;
        rd_req = 1'b0;
        m_ptr = 16'h0400;
        checks++; if (dval !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL simul dval %b busy %b req %b err %b exp 0 0 0 1", dval, busy, mem_req, err);
        end
        start_fetch(1'b1, a, tmo);
        checks++; if (tmo || a !== 16'h0400) begin errors++; $display("FAIL simul_addr got %h exp 0400", a); end
        send_beats(0, BL, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_fill();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int idx;
        bit tmo;
        do_cfg(16'h0500);
        start_fetch(1'b1, a, tmo);
        send_beats(0, 7, 1'b0, 1'b1);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL midrst_pre_err got %b exp 1", err); end
        #2 rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_addr !== '0 || dval !== 1'b0 || busy !== 1'b0 ||
                      err !== 1'b0 || weight_out !== '0) begin
            errors++;
            $display("FAIL midrst_async req %b addr %h dval %b busy %b err %b wout %h exp all 0",
                     mem_req, mem_addr, dval, busy, err, weight_out);
        end
        @(negedge clk);
        rst = 1'b0;
        m_ptr = '0;
        m_wout = '0;
        for (int i = 0; i < 9; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata = DW'($urandom);
            @(negedge clk);
        end
        mem_rvalid = 1'b0;
        checks++; if (dval !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_stale dval %b busy %b exp 0 0", dval, busy);
        end
        start_fetch(1'b1, a, tmo);
        checks++; if (tmo || a !== 16'h0000) begin errors++; $display("FAIL midrst_addr got %h exp 0000", a); end
        send_beats(0, BL, 1'b0, 1'b1);
        idx = int'($urandom_range(0, BL - 1));
        read_word(idx, d);
        checks++; if (d !== m_buf[idx]) begin
            errors++; $display("FAIL midrst_read idx %0d got %h exp %h", idx, d, m_buf[idx]);
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] d;
        do_cfg(16'h0700);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        for (int c = 0; c < 10; c++) begin
            mem_ready = 1'b0;
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata = DW'($urandom);
            checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0700 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_cyc %0d req %b addr %h busy %b exp 1 0700 1", c, mem_req, mem_addr, busy);
            end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = 16'hBEEF;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rvalid = 1'b0;
        send_beats(0, 15, 1'b0, 1'b1);
        checks++; if (dval !== 1'b0) begin errors++; $display("FAIL stall_dval_early got %b exp 0", dval); end
        send_beats(15, 1, 1'b0, 1'b1);
        checks++; if (dval !== 1'b1) begin errors++; $display("FAIL stall_dval got %b exp 1", dval); end
        for (int i = 0; i < BL; i++) begin
            read_word(i, d);
            checks++; if (d !== m_buf[i]) begin
                errors++; $display("FAIL stall_read idx %0d got %h exp %h", i, d, m_buf[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        cfg_wr = 1'b0;
        cfg_data = '0;
        rd_req = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        mem_rvalid = 1'b0;
        fifo_rd = 1'b0;
        fifo_idx = '0;
        m_ptr = '0;
        m_wout = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_second_fetch();
        test_wrap();
        test_drops();
        test_reset_mid_fill();
        test_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
